ahb_sram_slave: RTL and testbench
=================================

# ahb_sram_slave

AHB-Lite responder that bridges the system bus to a single-port synchronous SRAM macro (one-cycle read latency, per-byte write enables). It sits on an AHB-Lite slave port, between the bus system and the SRAM instance. It gives zero-wait-state reads and writes except for one wait state on a read that directly follows a write. It also checks transfer size and alignment and returns a two-cycle ERROR response for illegal transfers.

## Interface
Parameters:
- AW, 15: SRAM word-address width. Byte address bits [AW+1:2] select the word; upper bits are ignored, so the SRAM aliases across the select window.

Ports:
- HCLK  in  1  bus clock; all state on its rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select from the address decoder.
- HADDR  in  32  byte address.
- HTRANS  in  2  transfer type; bit 1 high means NONSEQ/SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = half, 2 = word; 3 to 7 are illegal.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-level ready; the address phase completes when it is high.
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  32  read data.
- SRAMCS  out  1  SRAM enable.
- SRAMWEN  out  4  byte write enables; all zero means read.
- SRAMADDR  out  AW  SRAM word address.
- SRAMWDATA  out  32  SRAM write data.
- SRAMRDATA  in  32  SRAM read data, valid the cycle after a read enable.

## Operation
- Accept condition: `acc = HSEL & HTRANS[1] & HREADY`. IDLE and BUSY transfers get an OKAY response with zero wait states and cause no SRAM access.
- Legal transfers:
  - HSIZE = 0 at any address.
  - HSIZE = 1 with HADDR[0] = 0.
  - HSIZE = 2 with HADDR[1:0] = 0.
  - Anything else is illegal.
- Byte mask:
  - byte: 4'b0001 << HADDR[1:0]
  - half: HADDR[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
- SRAMWDATA = HWDATA unmodified; the master replicates the byte lanes.
- Each accepted transfer registers its address, mask, direction and legality at the end of the address phase.
- FSM states: IDLE, WDATA, RDATA, RWAIT, ERR1, ERR2. The next state comes from the current transfer's `acc` and legality, evaluated in every state where HREADYOUT = 1:
  - legal read → RDATA, or RWAIT if the current state is WDATA;
  - legal write → WDATA;
  - illegal transfer → ERR1;
  - no `acc` → IDLE.
- Read with the port free (state is not WDATA): in the address-phase cycle, combinationally drive SRAMCS = 1, SRAMWEN = 0, SRAMADDR = HADDR[AW+1:2]. In RDATA, HRDATA = SRAMRDATA and HREADYOUT = 1.
- WDATA: SRAMCS = 1, SRAMWEN = registered mask, SRAMADDR = registered address, HREADYOUT = 1. Exactly one SRAM write is issued per write transfer.
- Read after write (read accepted while in WDATA): the port is busy, so the read address is registered and the FSM goes to RWAIT.
  - RWAIT: HREADYOUT = 0; SRAMCS = 1 read using the registered address; then go to RDATA.
  - RDATA returns the data just written, so it is coherent.
- ERR1: HRESP = 1, HREADYOUT = 0. ERR2: HRESP = 1, HREADYOUT = 1. No SRAM access occurs for an illegal transfer.
- A new transfer may be accepted in ERR2; it follows the normal FSM rules.
- HRDATA = 0 outside RDATA.
- SRAMCS = 0 and SRAMWEN = 0 in every cycle with no access listed above.

## Timing
- Reset values (asynchronous, held while HRESET = 1):
  - state = IDLE
  - HREADYOUT = 1, HRESP = 0, HRDATA = 0
  - SRAMCS = 0, SRAMWEN = 0, SRAMADDR = 0, SRAMWDATA = 0
- Reset during any phase drops any pending write or read; no SRAM access occurs in the cycle after reset is released.
- Read latency: data in the cycle after the address phase (0 wait states). A read directly after a write has 1 wait state.
- Write: the SRAM write occurs in the data-phase cycle. Back-to-back writes run at one per cycle.
- Read followed by write: no conflict. The read uses the port in its address phase and the write in its data phase.
- A read at address X directly after a write at address X must return the new data.
- ERROR response is always two cycles: HREADYOUT is 0 then 1, with HRESP = 1 in both.
- If HSEL is low but HREADY is high while this slave is in a data phase, the data phase still completes normally.

## Test plan
- Reset: assert HRESET mid-RWAIT → next cycle HREADYOUT = 1, HRESP = 0, SRAMCS = 0. After release, an IDLE transfer gets an OKAY response.
- Word write 0xDEADBEEF at 0x10, then word read at 0x20 (preloaded with 0x12345678) → SRAMWEN = 4'hF at word address 4. The read inserts one wait cycle and HRDATA = 0x12345678.
- Byte write 0xAA at 0x13, then word read at 0x10 with one IDLE cycle in between → SRAMWEN = 4'b1000. The read has zero waits and returns 0xAAADBEEF.
- Half write 0x5555 at 0x12, immediately followed by a read at 0x10 → one wait state, and the read returns 0x5555BEEF (RAW coherence).
- Illegal transfers: word at 0x02, and HSIZE = 3 → each gives HRESP = 1 for 2 cycles (HREADYOUT 0 then 1) and SRAMCS stays 0. The memory is unchanged.
- Aliasing: word read at 0x10 + (1 << (AW+2)) → SRAMADDR = 4, and the data equals the read at 0x10.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave
//
// AHB-Lite responder in front of a single-port synchronous SRAM macro
// (one-cycle read latency, per-byte write enables).
//
// Reads issue to the SRAM combinationally in their address phase, so data
// returns with zero wait states. Writes issue in their data phase, because
// HWDATA only becomes valid then. A read that arrives while a write owns the
// port is parked for one cycle (RWAIT) and re-issued from a registered
// address. That read therefore also sees the freshly written data.
// Illegal size/alignment combinations receive the two-cycle ERROR response
// and never touch the SRAM.
//
// Ports
//   HCLK, HRESET         bus clock, asynchronous active-high reset
//   HSEL, HADDR, HTRANS  address-phase controls from the bus
//   HWRITE, HSIZE        direction and transfer size
//   HWDATA               write data (data phase)
//   HREADY               bus-level ready (address phase completes when high)
//   HREADYOUT, HRESP     this slave's ready and response
//   HRDATA               read data (zero outside a read data phase)
//   SRAMCS, SRAMWEN      SRAM enable and per-byte write enables (0 = read)
//   SRAMADDR, SRAMWDATA  SRAM word address and write data
//   SRAMRDATA            SRAM read data, valid the cycle after a read enable
// ---------------------------------------------------------------------------
module ahb_sram_slave #(
    parameter int AW = 15
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    output logic          SRAMCS,
    output logic [3:0]    SRAMWEN,
    output logic [AW-1:0] SRAMADDR,
    output logic [31:0]   SRAMWDATA,
    input  logic [31:0]   SRAMRDATA
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WDATA = 3'd1;
    localparam logic [2:0] ST_RDATA = 3'd2;
    localparam logic [2:0] ST_RWAIT = 3'd3;
    localparam logic [2:0] ST_ERR1  = 3'd4;
    localparam logic [2:0] ST_ERR2  = 3'd5;

    // Size/alignment legality of an address-phase transfer.
    function automatic logic size_legal(input logic [2:0] size, input logic [1:0] low);
        case (size)
            3'd0:    size_legal = 1'b1;
            3'd1:    size_legal = (low[0] == 1'b0);
            3'd2:    size_legal = (low == 2'b00);
            default: size_legal = 1'b0;
        endcase
    endfunction

    // Byte-lane enables for a legal transfer.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] low);
        case (size)
            3'd0:    lane_mask = 4'b0001 << low;
            3'd1:    lane_mask = low[1] ? 4'b1100 : 4'b0011;
            3'd2:    lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    logic [2:0]    state_r;
    logic [2:0]    next_state_s;
    logic [AW-1:0] addr_r;
    logic [3:0]    mask_r;
    logic          ready_s;
    logic          acc_s;
    logic          take_s;
    logic          legal_s;
    logic          unused_bits_s;

    // Address bits above the SRAM window alias, and HTRANS[0] (SEQ vs NONSEQ)
    // does not change behaviour.
    assign unused_bits_s = ^{HADDR[31:AW+2], HTRANS[0]};

    // The slave only stalls in RWAIT and in the first ERROR cycle.
    assign ready_s = (state_r != ST_RWAIT) && (state_r != ST_ERR1);
    assign acc_s   = HSEL & HTRANS[1] & HREADY;
    // Only states that present HREADYOUT = 1 may accept a new transfer.
    assign take_s  = acc_s & ready_s;
    assign legal_s = size_legal(HSIZE, HADDR[1:0]);

    // Next-state selection. Direction and legality of the accepted transfer
    // are carried by the state itself.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_RWAIT: next_state_s = ST_RDATA;
            ST_ERR1:  next_state_s = ST_ERR2;
            ST_IDLE, ST_WDATA, ST_RDATA, ST_ERR2: begin
                if (!take_s) begin
                    next_state_s = ST_IDLE;
                end else if (!legal_s) begin
                    next_state_s = ST_ERR1;
                end else if (HWRITE) begin
                    next_state_s = ST_WDATA;
                end else if (state_r == ST_WDATA) begin
                    next_state_s = ST_RWAIT;
                end else begin
                    next_state_s = ST_RDATA;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State plus the address-phase capture used by WDATA and RWAIT.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_r <= ST_IDLE;
            addr_r  <= {AW{1'b0}};
            mask_r  <= 4'b0000;
        end else begin
            state_r <= next_state_s;
            if (take_s && legal_s) begin
                addr_r <= HADDR[AW+1:2];
                mask_r <= lane_mask(HSIZE, HADDR[1:0]);
            end
        end
    end

    // SRAM port arbitration. A pending write (WDATA) or parked read (RWAIT)
    // owns the port. Otherwise a newly accepted legal read uses it directly
    // in its address phase. Reset forces the port quiet.
    always_comb begin
        SRAMCS   = 1'b0;
        SRAMWEN  = 4'b0000;
        SRAMADDR = HADDR[AW+1:2];
        if (HRESET) begin
            SRAMADDR = {AW{1'b0}};
        end else if (state_r == ST_WDATA) begin
            SRAMCS   = 1'b1;
            SRAMWEN  = mask_r;
            SRAMADDR = addr_r;
        end else if (state_r == ST_RWAIT) begin
            SRAMCS   = 1'b1;
            SRAMADDR = addr_r;
        end else if (take_s && legal_s && !HWRITE) begin
            SRAMCS   = 1'b1;
        end else begin
            SRAMCS   = 1'b0;
        end
    end

    assign SRAMWDATA = HRESET ? 32'h0000_0000 : HWDATA;
    assign HREADYOUT = ready_s;
    assign HRESP     = (state_r == ST_ERR1) || (state_r == ST_ERR2);
    assign HRDATA    = (state_r == ST_RDATA) ? SRAMRDATA : 32'h0000_0000;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_sram_slave
//
// Drives pipelined AHB-Lite transfers into ahb_sram_slave, with HREADY tied
// back to HREADYOUT. The bench also models the SRAM macro. Expectations come
// from a byte-level reference memory and simple transfer rules: legality,
// wait count, byte lanes and word index.
// ---------------------------------------------------------------------------
module tb_ahb_sram_slave;
    localparam int AW    = 15;
    localparam int DEPTH = 1 << AW;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic          SRAMCS;
    logic [3:0]    SRAMWEN;
    logic [AW-1:0] SRAMADDR;
    logic [31:0]   SRAMWDATA;
    logic [31:0]   SRAMRDATA;

    ahb_sram_slave #(.AW(AW)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .SRAMCS(SRAMCS), .SRAMWEN(SRAMWEN), .SRAMADDR(SRAMADDR),
        .SRAMWDATA(SRAMWDATA), .SRAMRDATA(SRAMRDATA)
    );

    always #5 HCLK = ~HCLK;
    assign HREADY = HREADYOUT;

    function automatic logic [31:0] init_word(input int i);
        return (i == 8) ? 32'h1234_5678 : (32'(i) * 32'h9E37_79B9);
    endfunction

    // SRAM macro model: one-cycle read latency, byte write enables.
    logic [31:0] sram_mem [DEPTH];
    logic [31:0] sram_w;
    bit          pre_done = 1'b0;
    always @(posedge HCLK) begin
        if (!pre_done) begin
            for (int i = 0; i < DEPTH; i++) sram_mem[i] <= init_word(i);
            pre_done <= 1'b1;
        end else if (SRAMCS) begin
            if (SRAMWEN != 4'b0000) begin
                sram_w = sram_mem[SRAMADDR];
                for (int l = 0; l < 4; l++)
                    if (SRAMWEN[l]) sram_w[8*l +: 8] = SRAMWDATA[8*l +: 8];
                sram_mem[SRAMADDR] <= sram_w;
            end else begin
                SRAMRDATA <= sram_mem[SRAMADDR];
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        bit          active;
        bit          sel;
        bit          write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    xfer_t       q[$];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] last_rdata;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic bit legal_x(input xfer_t t);
        int nb;
        nb = 1 << t.size;
        return (t.size <= 3'd2) && ((t.addr % nb) == 0);
    endfunction

    function automatic logic [3:0] lanes_of(input xfer_t t);
        logic [3:0] m;
        m = 4'b0000;
        for (int b = 0; b < (1 << t.size); b++) m[(t.addr % 4) + b] = 1'b1;
        return m;
    endfunction

    task automatic ref_write(input xfer_t t);
        int w;
        int lane;
        w = word_of(t.addr);
        for (int b = 0; b < (1 << t.size); b++) begin
            lane = (t.addr % 4) + b;
            ref_mem[w][8*lane +: 8] = t.wdata[8*lane +: 8];
        end
    endtask

    function automatic xfer_t mk(input bit act, input bit sel, input bit wr,
                                 input logic [31:0] a, input logic [2:0] sz,
                                 input logic [31:0] wd);
        xfer_t t;
        t.active = act; t.sel = sel; t.write = wr;
        t.addr = a; t.size = sz; t.wdata = wd;
        return t;
    endfunction

    task automatic drive_ap(input xfer_t t);
        HSEL   = t.sel;
        HTRANS = t.active ? 2'b10 : 2'b00;
        HADDR  = t.addr;
        HWRITE = t.write;
        HSIZE  = t.size;
    endtask

    // Runs every queued transfer through the bus pipeline. Entered and left
    // just after a rising edge.
    task automatic run_queue();
        xfer_t cur, dp;
        bit    have_cur, cur_acc, dp_valid, dp_hazard, rdy, prev_w, dp_wlegal;
        int    dp_waits, budget, exp_waits;
        dp_valid = 1'b0; dp_hazard = 1'b0; dp_waits = 0; budget = 0;
        while ((q.size() != 0 || dp_valid) && budget < 5000) begin
            have_cur = (q.size() != 0);
            cur = have_cur ? q[0] : mk(1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
            drive_ap(cur);
            HWDATA = (dp_valid && dp.write) ? dp.wdata : 32'h0;
            @(negedge HCLK);
            rdy       = HREADYOUT;
            cur_acc   = cur.active && cur.sel;
            dp_wlegal = dp_valid && dp.write && legal_x(dp);
            if (dp_valid) begin
                if (!legal_x(dp)) begin
                    chk("err_resp", HRESP, 1);
                    if (!rdy) chk("err1_no_cs", SRAMCS, 0);
                end
                if (!rdy) begin
                    dp_waits++;
                    if (legal_x(dp) && !dp.write) begin
                        chk("rwait_cs", SRAMCS, 1);
                        chk("rwait_wen", SRAMWEN, 0);
                        chk("rwait_addr", SRAMADDR, word_of(dp.addr));
                    end
                end else begin
                    exp_waits = !legal_x(dp) ? 1 : ((!dp.write && dp_hazard) ? 1 : 0);
                    chk("wait_states", dp_waits, exp_waits);
                    if (legal_x(dp)) begin
                        chk("okay_resp", HRESP, 0);
                        if (dp.write) begin
                            chk("write_cs", SRAMCS, 1);
                            chk("write_wen", SRAMWEN, lanes_of(dp));
                            chk("write_addr", SRAMADDR, word_of(dp.addr));
                            chk("write_data", SRAMWDATA, dp.wdata);
                            ref_write(dp);
                        end else begin
                            chk("read_data", HRDATA, ref_mem[word_of(dp.addr)]);
                            last_rdata = HRDATA;
                        end
                    end
                end
            end else begin
                chk("idle_ready", rdy, 1);
                chk("idle_resp", HRESP, 0);
                chk("idle_rdata", HRDATA, 0);
            end
            if (rdy && cur_acc && !dp_wlegal) begin
                if (legal_x(cur) && !cur.write) begin
                    chk("ap_read_cs", SRAMCS, 1);
                    chk("ap_read_wen", SRAMWEN, 0);
                    chk("ap_read_addr", SRAMADDR, word_of(cur.addr));
                end else begin
                    chk("ap_no_cs", SRAMCS, 0);
                end
            end
            @(posedge HCLK); #1;
            if (rdy) begin
                prev_w   = dp_wlegal;
                dp_valid = 1'b0;
                if (have_cur) begin
                    void'(q.pop_front());
                    if (cur_acc) begin
                        dp = cur; dp_valid = 1'b1; dp_waits = 0; dp_hazard = prev_w;
                    end
                end
            end
            budget++;
        end
        chk("queue_drained", q.size() + int'(dp_valid), 0);
        drive_ap(mk(1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        xfer_t t;
        int    r;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        last_rdata = 32'h0;

        // Reset with an active read and write data on the bus: the port must stay quiet.
        HRESET = 1'b1;
        drive_ap(mk(1'b1, 1'b1, 1'b0, 32'h0000_0010, 3'd2, 32'h0));
        HWDATA = 32'hA5A5_A5A5;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_ready", HREADYOUT, 1);
        chk("rst_resp", HRESP, 0);
        chk("rst_rdata", HRDATA, 0);
        chk("rst_cs", SRAMCS, 0);
        chk("rst_wen", SRAMWEN, 0);
        chk("rst_addr", SRAMADDR, 0);
        chk("rst_wdata", SRAMWDATA, 0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        drive_ap(mk(1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0));

        // Word write then read of another word: one wait state.
        q.push_back(mk(1, 1, 1, 32'h0000_0010, 3'd2, 32'hDEAD_BEEF));
        q.push_back(mk(1, 1, 0, 32'h0000_0020, 3'd2, 32'h0));
        run_queue();
        chk("tp_preload_read", last_rdata, 32'h1234_5678);

        // Byte write, IDLE gap, word read: zero waits.
        q.push_back(mk(1, 1, 1, 32'h0000_0013, 3'd0, 32'hAAAA_AAAA));
        q.push_back(mk(0, 1, 0, 32'h0000_0000, 3'd0, 32'h0));
        q.push_back(mk(1, 1, 0, 32'h0000_0010, 3'd2, 32'h0));
        run_queue();
        chk("tp_byte_merge", last_rdata, 32'hAAAD_BEEF);

        // Half write immediately followed by a read of the same word.
        q.push_back(mk(1, 1, 1, 32'h0000_0012, 3'd1, 32'h5555_5555));
        q.push_back(mk(1, 1, 0, 32'h0000_0010, 3'd2, 32'h0));
        run_queue();
        chk("tp_raw_coherent", last_rdata, 32'h5555_BEEF);

        // Illegal transfers leave the memory untouched.
        q.push_back(mk(1, 1, 1, 32'h0000_0002, 3'd2, 32'hFFFF_FFFF));
        q.push_back(mk(1, 1, 1, 32'h0000_0010, 3'd3, 32'hFFFF_FFFF));
        q.push_back(mk(1, 1, 0, 32'h0000_0010, 3'd2, 32'h0));
        run_queue();
        chk("tp_illegal_nowrite", last_rdata, 32'h5555_BEEF);

        // Aliased address above the SRAM window.
        q.push_back(mk(1, 1, 0, 32'h0000_0010 | (32'h1 << (AW + 2)), 3'd2, 32'h0));
        run_queue();
        chk("tp_alias", last_rdata, 32'h5555_BEEF);

        // Reset asserted in the middle of an RWAIT cycle.
        drive_ap(mk(1, 1, 1, 32'h0000_0040, 3'd2, 32'h0));
        @(posedge HCLK); #1;
        drive_ap(mk(1, 1, 0, 32'h0000_0040, 3'd2, 32'h0));
        HWDATA = 32'h0BAD_F00D;
        @(posedge HCLK); #1;
        drive_ap(mk(0, 0, 0, 32'h0, 3'd0, 32'h0));
        @(negedge HCLK);
        chk("rwait_stall", HREADYOUT, 0);
        HRESET = 1'b1;
        #1;
        chk("mid_rst_ready", HREADYOUT, 1);
        chk("mid_rst_resp", HRESP, 0);
        chk("mid_rst_cs", SRAMCS, 0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        drive_ap(mk(0, 1, 0, 32'h0, 3'd0, 32'h0));
        @(negedge HCLK);
        chk("post_rst_ready", HREADYOUT, 1);
        chk("post_rst_resp", HRESP, 0);
        chk("post_rst_cs", SRAMCS, 0);
        @(posedge HCLK); #1;
        // The write completed in its data phase before the reset hit.
        ref_mem[16] = 32'h0BAD_F00D;
        q.push_back(mk(1, 1, 0, 32'h0000_0040, 3'd2, 32'h0));
        run_queue();

        // Randomized traffic over a small window, with random alias bits.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            t.active = (r >= 10);
            t.sel    = !(r >= 10 && r < 18);
            t.write  = 1'($urandom_range(0, 1));
            t.size   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7))
                                                   : 3'($urandom_range(0, 2));
            t.addr   = ($urandom & 32'hFFFE_0000) | 32'($urandom_range(0, 63));
            t.wdata  = $urandom;
            q.push_back(t);
        end
        run_queue();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
